// File: rtl/jpeg_stream_to_spi.sv
// Streams JFIF header ROM then encoder memory up to EOI into packed SPI words.
// Optional byte counter output enabled by `define JPEG_STREAM_BYTECNT_EN.
module jpeg_stream_to_spi #(
    parameter int HD_LEN     = 607,
    parameter int HD_AW      = 10,
    parameter int JE_AW      = 17,
    parameter int OUT_BYTES  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   je_done,
    output logic [HD_AW-1:0]       hd_addr,
    input  logic [7:0]             hd_data,
    output logic [JE_AW-1:0]       je_addr,
    input  logic [7:0]             je_data,
    input  logic                   spi_rd,
    output logic [8*OUT_BYTES-1:0] spi_data,
    output logic                   spi_valid,
    output logic                   spi_last,
    output logic [2:0]             spi_nbytes,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_underflow,
    output logic                   err_noeoi
`ifdef JPEG_STREAM_BYTECNT_EN
    ,
    output logic [31:0]            frame_bytes
`endif
);

    localparam int W  = 8 * OUT_BYTES;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);
    localparam logic [2:0] OB_W = 3'(OUT_BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HDR   = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state;
    logic          rd_v;
    logic          rd_src;
    logic          rd_end;
    logic          je_end;
    logic          prev_ff;
    logic [2:0]    pk_cnt;
    logic [W-1:0]  pk_data;
    logic [W-1:0]  pk_next;

    logic [W-1:0]  f_data [FIFO_DEPTH];
    logic [2:0]    f_nb   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] f_last;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   f_cnt;

    logic          start;
    logic          pop;
    logic          push;
    logic [7:0]    cap_byte;
    logic          cap_eoi;
    logic          cap_noeoi;
    logic          cap_last;
    logic          pend;
    logic [PW+1:0] occ;
    logic          room;
    logic          issue_hd;
    logic          issue_je;

    assign start     = (state == S_IDLE) && je_done;
    assign spi_valid = (f_cnt != '0);
    assign pop       = spi_rd && spi_valid;
    assign cap_byte  = rd_src ? je_data : hd_data;
    assign cap_eoi   = rd_v && rd_src && prev_ff && (je_data == 8'hD9);
    assign cap_noeoi = rd_v && rd_src && rd_end && !cap_eoi;
    assign cap_last  = cap_eoi || cap_noeoi;

    // Packer plus in-flight byte can never span more than one word.
    assign pend     = (pk_cnt != 3'd0) || rd_v;
    assign occ      = {1'b0, f_cnt} + {{(PW+1){1'b0}}, pend};
    assign room     = occ < DEPTH_W;
    assign issue_hd = (state == S_HDR) && room;
    assign issue_je = (state == S_DATA) && room && !je_end && !cap_last;

    always_comb begin
        pk_next = pk_data;
        for (int i = 0; i < OUT_BYTES; i++) begin
            if (pk_cnt == 3'(i)) begin
                pk_next[8*(OUT_BYTES-1-i) +: 8] = cap_byte;
            end
        end
        push = rd_v && (((pk_cnt + 3'd1) == OB_W) || cap_last);
    end

    assign spi_data   = spi_valid ? f_data[rd_ptr] : '0;
    assign spi_nbytes = spi_valid ? f_nb[rd_ptr] : 3'd0;
    assign spi_last   = spi_valid && f_last[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err_underflow <= 1'b0;
            err_noeoi     <= 1'b0;
            hd_addr       <= '0;
            je_addr       <= '0;
            je_end        <= 1'b0;
            prev_ff       <= 1'b0;
            rd_v          <= 1'b0;
            rd_src        <= 1'b0;
            rd_end        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_v       <= issue_hd || issue_je;
            rd_src     <= issue_je;
            rd_end     <= issue_je && (je_addr == '1);
            if (rd_v && rd_src) begin
                prev_ff <= (je_data == 8'hFF);
            end
            unique case (state)
                S_IDLE: begin
                    if (je_done) begin
                        busy          <= 1'b1;
                        err_underflow <= 1'b0;
                        err_noeoi     <= 1'b0;
                        hd_addr       <= '0;
                        je_addr       <= '0;
                        je_end        <= 1'b0;
                        prev_ff       <= 1'b0;
                        state         <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (issue_hd) begin
                        if (hd_addr == HD_AW'(HD_LEN - 1)) begin
                            je_addr <= '0;
                            state   <= S_DATA;
                        end else begin
                            hd_addr <= hd_addr + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (issue_je) begin
                        je_addr <= je_addr + 1'b1;
                        if (je_addr == '1) begin
                            je_end <= 1'b1;
                        end
                    end
                    if (cap_last) begin
                        state <= S_DRAIN;
                        if (cap_noeoi) begin
                            err_noeoi <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && spi_last) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (spi_rd && !spi_valid) begin
                err_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pk_cnt  <= 3'd0;
            pk_data <= '0;
        end else if (rd_v) begin
            if (push) begin
                pk_cnt  <= 3'd0;
                pk_data <= '0;
            end else begin
                pk_cnt  <= pk_cnt + 3'd1;
                pk_data <= pk_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            f_cnt  <= '0;
            f_last <= '0;
        end else begin
            if (push) begin
                wr_ptr         <= wr_ptr + 1'b1;
                f_last[wr_ptr] <= cap_last;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            f_cnt <= f_cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_data[wr_ptr] <= pk_next;
            f_nb[wr_ptr]   <= pk_cnt + 3'd1;
        end
    end

`ifdef JPEG_STREAM_BYTECNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_bytes <= '0;
        end else if (start) begin
            frame_bytes <= '0;
        end else if (rd_v) begin
            frame_bytes <= frame_bytes + 32'd1;
        end
    end
`endif

endmodule

// File: doc/jpeg_stream_to_spi.md
Name: jpeg_stream_to_spi

Overview:
- Parametrised successor to the single-byte JPEG-to-SPI bridge.
- On an encoder-done pulse, it streams the fixed JFIF header ROM and then the encoder output memory until the EOI marker (FF D9).
- Bytes pass through a prefetch FIFO and are packed into OUT_BYTES-wide words for the SPI slave.
- It sits between the header ROM / encoder output RAM (both 1-cycle synchronous read) and the SPI slave's read port.

Parameters:
- HD_LEN, 607: number of header ROM bytes emitted, at addresses 0..HD_LEN-1.
- HD_AW, 10: header ROM address width; 2^HD_AW must be >= HD_LEN.
- JE_AW, 17: encoder memory address width.
- OUT_BYTES, 1: bytes per output word, legal values 1, 2, 4; spi_data width is 8*OUT_BYTES.
- FIFO_DEPTH, 8: prefetch FIFO depth in words; power of 2, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- je_done  in  1  single-cycle start pulse from the JPEG encoder.
- hd_addr  out  HD_AW  header ROM address.
- hd_data  in  8  header ROM data, valid 1 cycle after the address edge.
- je_addr  out  JE_AW  encoder memory address.
- je_data  in  8  encoder memory data, valid 1 cycle after the address edge.
- spi_rd  in  1  pop the head word.
- spi_data  out  8*OUT_BYTES  head word; first stream byte sits in the MSB byte.
- spi_valid  out  1  FIFO non-empty.
- spi_last  out  1  head word holds the final stream byte.
- spi_nbytes  out  3  valid bytes in the head word, 1..OUT_BYTES; padding bytes are 0x00 in the LSBs.
- busy  out  1  high from start until the last word is popped.
- frame_done  out  1  1-cycle pulse after the last word is popped.
- err_underflow  out  1  sticky flag: spi_rd seen while spi_valid=0; cleared by the next start.
- err_noeoi  out  1  sticky flag: encoder memory exhausted without EOI; cleared by the next start.

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; addresses 0; packer empty.
- Address timing: address driven at edge k, data captured at edge k+1. A fetch is issued only if (FIFO occupancy + in-flight words + partial packer word) < FIFO_DEPTH, so the FIFO never overflows.
- IDLE: waits for je_done=1. On the pulse: busy<=1, error flags cleared, hd_addr=0, go to HDR.
- HDR:
  - Fetch hd_addr 0..HD_LEN-1, incrementing by 1 per issued fetch.
  - After issuing HD_LEN-1, go to DATA with je_addr=0.
  - The header FF bytes never trigger EOI detection.
- DATA:
  - Fetch je_addr incrementing by 1.
  - EOI is detected on a captured encoder byte D9 whose previous captured encoder byte was FF; that D9 is the last byte.
  - Stop issuing when EOI is detected. Discard up to one speculatively in-flight byte.
  - Go to DRAIN.
- DATA, no EOI: if address 2^JE_AW-1 is captured without EOI, set err_noeoi, treat that byte as last, go to DRAIN.
- Packer:
  - Shifts bytes MSB-first.
  - Pushes a word to the FIFO when OUT_BYTES bytes are collected, or on the last byte with zero padding.
  - spi_nbytes and spi_last are stored per FIFO entry.
- DRAIN: no fetches. When the word with spi_last=1 is popped (spi_rd=1 and spi_valid=1): frame_done pulses, busy<=0, go to IDLE.
- SPI side:
  - spi_data, spi_last and spi_nbytes show the head entry combinationally from FIFO registers.
  - The pop takes effect at the edge; the new head is visible in the next cycle.
  - Simultaneous push and pop is allowed at any occupancy.
  - spi_rd while empty: err_underflow<=1; FIFO and data unchanged.
- je_done while busy: ignored; the stream is not restarted.
- Asynchronous reset mid-frame: immediate return to the reset state; no frame_done.
- Total stream bytes = HD_LEN + (EOI index + 1). Words = ceil(bytes/OUT_BYTES).

Optional Feature:
- Macro JPEG_STREAM_BYTECNT_EN.
- Defined: adds output frame_bytes [31:0].
  - Cleared at start.
  - Incremented per byte pushed into the packer.
  - Holds its final value from the frame_done pulse until the next start.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- OUT_BYTES=1, header ROM per file, EOI at encoder indices 10240/10241, spi_rd every 8th cycle -> 607 header bytes in order, then encoder bytes 0..10241; last byte D9 with spi_last=1; one frame_done; 10849 pops total.
- OUT_BYTES=4, same data -> 2713 words; final word has spi_nbytes=1 and bytes {D9,00,00,00}; first word = ROM[0..3] MSB-first.
- spi_rd held high continuously from the start pulse -> err_underflow=1 during early cycles; no duplicated or lost bytes; byte stream still matches.
- Encoder memory with no FF D9 and JE_AW=8 -> err_noeoi=1; stream ends at address 255 with spi_last=1.
- Second je_done mid-stream, then async reset at byte 300 -> first pulse ignored; after reset all outputs are 0; a fresh je_done streams correctly from ROM[0].
- JPEG_STREAM_BYTECNT_EN defined, first scenario -> frame_bytes=10849 at frame_done.
